// File: rtl/bus_pkg.sv
// Shared constants for the bus arbiter/mux slice.
// The optional counter (macro BUS_CONFLICT_CNT_EN) is sized here.
package bus_pkg;
  localparam int CONFLICT_CNT_W = 16;
  localparam int MODE_PRIO      = 0;
  localparam int MODE_RR        = 1;
  localparam int DEF_N_SRC      = 24;
  localparam int DEF_WIDTH      = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Winner search (fixed priority or round-robin) and the rr pointer.
// The pointer advances on the final winner chosen by the top.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter  int N_SRC   = DEF_N_SRC,
  parameter  int RR_MODE = MODE_PRIO,
  localparam int IW      = idx_w(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] req_i,
  input  logic             upd_i,
  input  logic [IW-1:0]    upd_idx_i,
  output logic             win_vld_o,
  output logic [IW-1:0]    win_idx_o
);

  localparam logic [IW:0] NS = (IW+1)'(N_SRC);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   pos;

  // Descending offset scan: the last hit is the one nearest the pointer.
  always_comb begin
    win_vld_o = 1'b0;
    win_idx_o = '0;
    pos       = '0;
    if (RR_MODE == MODE_RR) begin
      for (int k = N_SRC-1; k >= 0; k--) begin
        pos = {1'b0, ptr_q} + (IW+1)'(k);
        if (pos >= NS) pos = pos - NS;
        if (req_i[pos[IW-1:0]]) begin
          win_vld_o = 1'b1;
          win_idx_o = pos[IW-1:0];
        end
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (req_i[i]) begin
          win_vld_o = 1'b1;
          win_idx_o = IW'(i);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = (upd_idx_i == IW'(N_SRC-1)) ? '0
            : upd_idx_i + IW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (RR_MODE == MODE_RR) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered N-source bus mux with lockable arbitration.
// Macro BUS_CONFLICT_CNT_EN adds a saturating conflict counter.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter  int N_SRC   = DEF_N_SRC,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int RR_MODE = MODE_PRIO,
  localparam int IW      = idx_w(N_SRC)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       src_req,
  input  logic [N_SRC-1:0]       src_lock,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [N_SRC-1:0]       grant,
  output logic                   conflict
`ifdef BUS_CONFLICT_CNT_EN
  ,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

  logic             arb_vld;
  logic [IW-1:0]    arb_idx;
  logic             lock_hit;
  logic             sel_vld;
  logic [IW-1:0]    sel_idx;
  logic             own_vld_q, own_vld_d;
  logic [IW-1:0]    own_idx_q, own_idx_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic             valid_q;
  logic             conf_q, conf_d;

  rr_arbiter #(
    .N_SRC   (N_SRC),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk_i     (clock),
    .rst_i     (reset),
    .req_i     (src_req),
    .upd_i     (sel_vld),
    .upd_idx_i (sel_idx),
    .win_vld_o (arb_vld),
    .win_idx_o (arb_idx)
  );

  // A live owner pre-empts the search; a dropped request falls through.
  always_comb begin
    lock_hit  = own_vld_q & src_req[own_idx_q];
    sel_vld   = lock_hit | arb_vld;
    sel_idx   = lock_hit ? own_idx_q : arb_idx;
    grant_d   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      grant_d[i] = sel_vld && (sel_idx == IW'(i));
    end
    bus_d     = sel_vld ? src_data[int'(sel_idx)*WIDTH +: WIDTH]
                        : bus_q;
    own_vld_d = sel_vld & src_lock[sel_idx];
    own_idx_d = sel_idx;
    conf_d    = |(src_req & (src_req - N_SRC'(1)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      conf_q    <= 1'b0;
      own_vld_q <= 1'b0;
      own_idx_q <= '0;
    end else begin
      bus_q     <= bus_d;
      grant_q   <= grant_d;
      valid_q   <= sel_vld;
      conf_q    <= conf_d;
      own_vld_q <= own_vld_d;
      own_idx_q <= own_idx_d;
    end
  end

  assign bus_out   = bus_q;
  assign grant     = grant_q;
  assign bus_valid = valid_q;
  assign conflict  = conf_q;

`ifdef BUS_CONFLICT_CNT_EN
  logic [CONFLICT_CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = (conf_q && (cnt_q != '1))
               ? cnt_q + CONFLICT_CNT_W'(1) : cnt_q;

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule
